// File: rtl/whack_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : whack_game_ctrl
// Description : Whack-a-mole controller. Produces game state, score and miss
//               count; optional WHACK_SPEEDUP_EN shortens moles on each hit.
// Revision    : 1.0  initial release
// ============================================================================
module whack_game_ctrl #(
  parameter int MOLE_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 12_500_000,
  parameter int MISS_LIMIT = 3
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iStart,
  input  logic [3:0] iKeys,
  output logic [2:0] oState,
  output logic [7:0] oScore,
  output logic [3:0] oMisses,
  output logic       oNewFrame
);

  localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_TICKS - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [3:0]    MISS_MAX  = 4'(MISS_LIMIT);

  localparam logic [2:0] S_START    = 3'b000;
  localparam logic [2:0] S_GAME     = 3'b001;
  localparam logic [2:0] S_MOLE1    = 3'b010;
  localparam logic [2:0] S_MOLE2    = 3'b011;
  localparam logic [2:0] S_MOLE3    = 3'b100;
  localparam logic [2:0] S_MOLE4    = 3'b101;
  localparam logic [2:0] S_GAMEOVER = 3'b110;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    keys_q, keys_d;
  logic          start_q, start_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    misses_q, misses_d;
  logic          new_frame_q, new_frame_d;

  logic [3:0]    key_edge;
  logic          start_edge;
  logic [1:0]    mole_idx;
  logic          timer_zero;
  logic [TW-1:0] mole_last;

`ifdef WHACK_SPEEDUP_EN
  localparam logic [TW-1:0] STEP       = TW'(MOLE_TICKS / 16);
  localparam logic [TW-1:0] FLOOR_LAST = TW'(MOLE_TICKS / 4 - 1);

  logic [TW-1:0] mole_last_q, mole_last_d;
  assign mole_last = mole_last_q;

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      mole_last_q <= MOLE_LAST;
    end else begin
      mole_last_q <= mole_last_d;
    end
  end
`else
  assign mole_last = MOLE_LAST;
`endif

  // State register (all flops)
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q     <= S_START;
      timer_q     <= '0;
      lfsr_q      <= 8'hA5;
      keys_q      <= 4'b0000;
      start_q     <= 1'b0;
      score_q     <= 8'd0;
      misses_q    <= 4'd0;
      new_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      keys_q      <= keys_d;
      start_q     <= start_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      new_frame_q <= new_frame_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    keys_d      = iKeys;
    start_d     = iStart;
    key_edge    = iKeys & ~keys_q;
    start_edge  = iStart & ~start_q;
    mole_idx    = 2'(state_q - S_MOLE1);
    timer_zero  = (timer_q == '0);
    state_d     = state_q;
    timer_d     = timer_q;
    score_d     = score_q;
    misses_d    = misses_q;
`ifdef WHACK_SPEEDUP_EN
    mole_last_d = mole_last_q;
`endif

    case (state_q)
      S_START: begin
        if (start_edge) begin
          score_d  = 8'd0;
          misses_d = 4'd0;
          timer_d  = GAP_LAST;
          state_d  = S_GAME;
`ifdef WHACK_SPEEDUP_EN
          mole_last_d = MOLE_LAST;
`endif
        end
      end
      S_GAME: begin
        if (timer_zero) begin
          state_d = S_MOLE1 + {1'b0, lfsr_q[1:0]};
          timer_d = mole_last;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_MOLE1, S_MOLE2, S_MOLE3, S_MOLE4: begin
        if (key_edge[mole_idx]) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          timer_d = GAP_LAST;
          state_d = S_GAME;
`ifdef WHACK_SPEEDUP_EN
          mole_last_d = (mole_last_q >= FLOOR_LAST + STEP) ? mole_last_q - STEP : FLOOR_LAST;
`endif
        end else if ((key_edge != 4'b0000) || timer_zero) begin
          // A wrong key on the final cycle is one miss and still ends the mole.
          misses_d = misses_q + 4'd1;
          if (misses_d == MISS_MAX) begin
            state_d = S_GAMEOVER;
          end else if (timer_zero) begin
            timer_d = GAP_LAST;
            state_d = S_GAME;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_GAMEOVER: begin
        if (start_edge) begin
          state_d = S_START;
        end
      end
      default: begin
        state_d = S_START;
      end
    endcase

    new_frame_d = (state_d != state_q);
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Outputs
  always_comb begin
    oState    = state_q;
    oScore    = score_q;
    oMisses   = misses_q;
    oNewFrame = new_frame_q;
  end

endmodule
`default_nettype wire
